// File: rtl/bsg_link_pkg.sv
`default_nettype none
// ============================================================================
//  Package     : bsg_link_pkg
//  Description : Constants and FSM state type shared by the upstream and
//                downstream halves of the credit-based serial link.
//  Revision    : 1.0 - initial release
// ============================================================================
package bsg_link_pkg;

    localparam int WORD_W      = 4;   // core word width
    localparam int FLIT_W      = 2;   // link flit width (io cycles per flit)
    localparam int CREDIT_INIT = 8;   // receiver buffer depth in flits
    localparam int TOKEN_FLITS = 4;   // flits returned per token toggle

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

endpackage : bsg_link_pkg
`default_nettype wire

// File: rtl/bsg_up_word_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : bsg_up_word_fifo
//  Description : Core-side word FIFO for the upstream channel. Pointers carry
//                an extra wrap bit so full and empty are distinguishable.
//  Revision    : 1.0 - initial release
// ============================================================================
module bsg_up_word_fifo #(
    parameter int WIDTH = 4,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push_valid,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign empty   = (wr_ptr == rd_ptr);
    assign do_push = push_valid && !full;
    assign do_pop  = pop && !empty;
    assign head    = mem[rd_ptr[AW-1:0]];

    // Pointer update; a push and a pop in the same cycle both advance.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    // Storage write; contents need no reset because the pointers gate reads.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= push_data;
    end

endmodule : bsg_up_word_fifo
`default_nettype wire

// File: rtl/bsg_upstream_ch.sv
`default_nettype none
// ============================================================================
//  Module      : bsg_upstream_ch
//  Description : Upstream half of a credit-based serial link. Buffers core
//                words, serializes them LSB first onto a 1-bit io lane and
//                tracks flit credits returned by a toggling token.
//  Revision    : 1.0 - initial release
// ============================================================================
module bsg_upstream_ch #(
    parameter int WORD_W      = bsg_link_pkg::WORD_W,
    parameter int FLIT_W      = bsg_link_pkg::FLIT_W,
    parameter int FIFO_DEPTH  = 4,
    parameter int CREDIT_INIT = bsg_link_pkg::CREDIT_INIT
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              core_valid_in,
    input  logic [WORD_W-1:0] core_data_in,
    output logic              core_ready_out,
    input  logic              io_token_in,
    output logic              io_valid_out,
    output logic              io_data_out,
    output logic [3:0]        credits_out
);

    import bsg_link_pkg::*;

    localparam int              CNT_W    = $clog2(WORD_W);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WORD_W - 1);
    // Credit arithmetic is one bit wider than the counter so overflow is visible.
    localparam logic [4:0]      COST     = 5'(WORD_W / FLIT_W);
    localparam logic [4:0]      RETURN   = 5'(TOKEN_FLITS);
    localparam logic [4:0]      CAP      = 5'(CREDIT_INIT);

    logic [WORD_W-1:0] head;
    logic              fifo_full;
    logic              fifo_empty;
    logic              load;
    logic              can_load;
    logic              tok_event;
    logic [4:0]        credit_sum;
    logic [CNT_W-1:0]  next_cnt;

    state_t            state;
    logic [CNT_W-1:0]  bit_cnt;
    logic [WORD_W-1:0] shreg;
    logic [3:0]        credits;
    logic              tok_r;
    logic              io_valid_r;
    logic              io_data_r;

    bsg_up_word_fifo #(
        .WIDTH (WORD_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk        (clk),
        .rst        (rst),
        .push_valid (core_valid_in),
        .push_data  (core_data_in),
        .pop        (load),
        .head       (head),
        .full       (fifo_full),
        .empty      (fifo_empty)
    );

    assign core_ready_out = !fifo_full;
    assign io_valid_out   = io_valid_r;
    assign io_data_out    = io_data_r;
    assign credits_out    = credits;

    // A word may start when one is queued and the receiver has room for both flits.
    assign can_load  = !fifo_empty && ({1'b0, credits} >= COST);
    // Loads happen from IDLE or back-to-back on the last bit of the current word.
    assign load      = can_load && ((state == IDLE) || (bit_cnt == LAST_BIT));
    assign tok_event = io_token_in ^ tok_r;
    assign next_cnt  = bit_cnt + 1'b1;
    // Net credit change; cannot underflow since a load requires credits >= COST.
    assign credit_sum = {1'b0, credits}
                      + (tok_event ? RETURN : 5'd0)
                      - (load      ? COST   : 5'd0);

    // Serializer FSM with registered io outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            bit_cnt    <= '0;
            shreg      <= '0;
            io_valid_r <= 1'b0;
            io_data_r  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (load) begin
                        shreg      <= head;
                        bit_cnt    <= '0;
                        io_valid_r <= 1'b1;
                        io_data_r  <= head[0];
                        state      <= SHIFT;
                    end else begin
                        io_valid_r <= 1'b0;
                        io_data_r  <= 1'b0;
                    end
                end
                SHIFT: begin
                    if (bit_cnt == LAST_BIT) begin
                        if (load) begin
                            shreg      <= head;
                            bit_cnt    <= '0;
                            io_valid_r <= 1'b1;
                            io_data_r  <= head[0];
                        end else begin
                            bit_cnt    <= '0;
                            io_valid_r <= 1'b0;
                            io_data_r  <= 1'b0;
                            state      <= IDLE;
                        end
                    end else begin
                        bit_cnt   <= next_cnt;
                        io_data_r <= shreg[next_cnt];
                    end
                end
                default: begin
                    state      <= IDLE;
                    bit_cnt    <= '0;
                    io_valid_r <= 1'b0;
                    io_data_r  <= 1'b0;
                end
            endcase
        end
    end

    // Credit counter and token edge detector.
    always_ff @(posedge clk) begin
        if (rst) begin
            credits <= CAP[3:0];
            tok_r   <= 1'b0;
        end else begin
            tok_r   <= io_token_in;
            credits <= (credit_sum > CAP) ? CAP[3:0] : credit_sum[3:0];
        end
    end

    // Returning more credits than the receiver buffer holds is a protocol error.
    a_credit_overflow : assert property (@(posedge clk) disable iff (rst) credit_sum <= CAP);

endmodule : bsg_upstream_ch
`default_nettype wire

// File: tb/tb_bsg_upstream_ch.sv
`default_nettype none
// ============================================================================
//  Module      : tb_bsg_upstream_ch
//  Description : Directed self-checking bench for bsg_upstream_ch.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_bsg_upstream_ch;

    logic       clk           = 1'b0;
    logic       rst           = 1'b1;
    logic       core_valid_in = 1'b0;
    logic [3:0] core_data_in  = 4'h0;
    logic       core_ready_out;
    logic       io_token_in   = 1'b0;
    logic       io_valid_out;
    logic       io_data_out;
    logic [3:0] credits_out;

    int   checks   = 0;
    int   failures = 0;
    logic rx_bits[$];

    always #5 clk = ~clk;

    bsg_upstream_ch dut (
        .clk            (clk),
        .rst            (rst),
        .core_valid_in  (core_valid_in),
        .core_data_in   (core_data_in),
        .core_ready_out (core_ready_out),
        .io_token_in    (io_token_in),
        .io_valid_out   (io_valid_out),
        .io_data_out    (io_data_out),
        .credits_out    (credits_out)
    );

    // Capture every valid serial bit in arrival order.
    always @(negedge clk) begin
        if (!rst && io_valid_out) rx_bits.push_back(io_data_out);
    end

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic step_n(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic push_word(input logic [3:0] w);
        core_valid_in = 1'b1;
        core_data_in  = w;
        step();
        core_valid_in = 1'b0;
    endtask

    task automatic do_reset();
        rst           = 1'b1;
        core_valid_in = 1'b0;
        io_token_in   = 1'b0;
        step_n(2);
        rst = 1'b0;
        rx_bits.delete();
    endtask

    // Received bits packed with the first bit at position 0.
    function automatic logic [31:0] rx_val();
        logic [31:0] v;
        v = '0;
        for (int i = 0; i < rx_bits.size() && i < 32; i++) v[i] = rx_bits[i];
        return v;
    endfunction

    initial begin
        logic [3:0] w;
        logic [7:0] pair;

        // Reset state and a single word with full credits.
        do_reset();
        check("rst_valid",   32'(io_valid_out),   32'd0);
        check("rst_data",    32'(io_data_out),    32'd0);
        check("rst_credits", 32'(credits_out),    32'd8);
        check("rst_ready",   32'(core_ready_out), 32'd1);
        w = 4'hA;
        push_word(w);
        check("t1_no_early", 32'(io_valid_out), 32'd0);
        step();
        check("t1_credits", 32'(credits_out), 32'd6);
        for (int i = 0; i < 4; i++) begin
            check("t1_valid", 32'(io_valid_out), 32'd1);
            check("t1_bit",   32'(io_data_out),  32'(w[i]));
            step();
        end
        check("t1_idle_valid", 32'(io_valid_out), 32'd0);
        check("t1_idle_data",  32'(io_data_out),  32'd0);
        check("t1_stream",     rx_val(),          32'hA);

        // Two consecutive words stream back-to-back.
        do_reset();
        core_valid_in = 1'b1;
        core_data_in  = 4'h3;
        step();
        core_data_in  = 4'hC;
        step();
        core_valid_in = 1'b0;
        pair = 8'hC3;
        for (int i = 0; i < 8; i++) begin
            check("t2_valid", 32'(io_valid_out), 32'd1);
            check("t2_bit",   32'(io_data_out),  32'(pair[i]));
            step();
        end
        check("t2_gap_end", 32'(io_valid_out), 32'd0);
        check("t2_credits", 32'(credits_out),  32'd4);

        // Credit exhaustion holds the fifth word until a token returns.
        do_reset();
        push_word(4'h1);
        push_word(4'h2);
        push_word(4'h4);
        push_word(4'h8);
        push_word(4'hF);
        step_n(15);
        check("t3_credits0", 32'(credits_out),    32'd0);
        check("t3_held",     32'(io_valid_out),   32'd0);
        check("t3_ready",    32'(core_ready_out), 32'd1);
        check("t3_stream4",  rx_val(),            32'h8421);
        io_token_in = 1'b1;
        step();
        check("t3_tok_credits", 32'(credits_out),  32'd4);
        check("t3_tok_valid",   32'(io_valid_out), 32'd0);
        step();
        check("t3_fifth_valid", 32'(io_valid_out), 32'd1);
        check("t3_fifth_cred",  32'(credits_out),  32'd2);
        step_n(4);
        check("t3_count",   32'(rx_bits.size()), 32'd20);
        check("t3_stream5", rx_val(),            32'hF8421);

        // Fill the FIFO with no credits; a push while full is dropped.
        do_reset();
        push_word(4'h1);
        push_word(4'h1);
        push_word(4'h1);
        push_word(4'h1);
        step_n(16);
        check("t4_credits0", 32'(credits_out), 32'd0);
        rx_bits.delete();
        w = 4'h5; check("t4_ready_a", 32'(core_ready_out), 32'd1); push_word(w);
        w = 4'h6; check("t4_ready_b", 32'(core_ready_out), 32'd1); push_word(w);
        w = 4'h9; check("t4_ready_c", 32'(core_ready_out), 32'd1); push_word(w);
        w = 4'hE; check("t4_ready_d", 32'(core_ready_out), 32'd1); push_word(w);
        check("t4_full", 32'(core_ready_out), 32'd0);
        push_word(4'h7);
        check("t4_still_full", 32'(core_ready_out), 32'd0);
        io_token_in = 1'b1;
        step();
        check("t4_tok1", 32'(credits_out), 32'd4);
        step_n(12);
        io_token_in = 1'b0;
        step();
        check("t4_tok2", 32'(credits_out), 32'd4);
        step_n(10);
        check("t4_count",  32'(rx_bits.size()), 32'd16);
        check("t4_stream", rx_val(),            32'hE965);
        check("t4_empty",  32'(core_ready_out), 32'd1);
        check("t4_idle",   32'(io_valid_out),   32'd0);

        // Token return in the same cycle as a load with two credits left.
        do_reset();
        push_word(4'h1);
        push_word(4'h1);
        push_word(4'h1);
        step_n(14);
        check("t5_credits2", 32'(credits_out), 32'd2);
        push_word(4'hA);
        io_token_in = 1'b1;
        step();
        check("t5_net",   32'(credits_out),  32'd4);
        check("t5_valid", 32'(io_valid_out), 32'd1);
        step_n(5);
        check("t5_done", 32'(io_valid_out), 32'd0);

        // Reset in the middle of a word aborts it and empties the FIFO.
        do_reset();
        w = 4'hA;
        push_word(w);
        push_word(4'hB);
        step_n(2);
        check("t6_mid_valid", 32'(io_valid_out), 32'd1);
        check("t6_mid_bit",   32'(io_data_out),  32'(w[2]));
        rst = 1'b1;
        step();
        check("t6_valid",   32'(io_valid_out),   32'd0);
        check("t6_data",    32'(io_data_out),    32'd0);
        check("t6_credits", 32'(credits_out),    32'd8);
        check("t6_ready",   32'(core_ready_out), 32'd1);
        rst = 1'b0;
        rx_bits.delete();
        step_n(6);
        check("t6_fifo_empty", 32'(rx_bits.size()), 32'd0);
        check("t6_quiet",      32'(io_valid_out),   32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_bsg_upstream_ch
`default_nettype wire
